// File: rtl/word_store_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | word_store_pkg : shared types and widths for word_store_serializer |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package word_store_pkg;

    localparam int BEAT_W      = 16;
    localparam int WORD_W      = 32;
    localparam int HALF_OFFSET = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/word_store_serializer_beat_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | beat_wait_counter : counts stalled beat cycles, flags MAX_WAIT     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module beat_wait_counter #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry fires on the MAX_WAIT-th stalled cycle itself, not one later.
    always_comb begin
        expired = enable && !clear && (cnt_q == CNT_W'(MAX_WAIT - 1));
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_store_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | word_store_serializer : 32-bit store -> two 16-bit big-endian beats |
// | Optional macro HALF_STORE_EN adds req_half (single-beat sh store). |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module word_store_serializer
    import word_store_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_data,
`ifdef HALF_STORE_EN
    input  logic              req_half,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                half_q, half_d;

    logic                req_ready_q, req_ready_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                req_half_w;
    logic                misaligned_w;
    logic                in_beat_w;
    logic                wait_clear_w;
    logic                wait_en_w;
    logic                timeout_w;

`ifdef HALF_STORE_EN
    assign req_half_w = req_half;
`else
    assign req_half_w = 1'b0;
`endif

    assign misaligned_w = req_half_w ? req_addr[0] : (req_addr[1:0] != 2'b00);
    assign in_beat_w    = (state_q == HI) || (state_q == LO);
    assign wait_en_w    = in_beat_w && !mem_ready;
    assign wait_clear_w = !in_beat_w || mem_ready;

    beat_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear_w),
        .enable  (wait_en_w),
        .expired (timeout_w)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        half_d  = half_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    half_d  = req_half_w;
                    state_d = misaligned_w ? ERR : HI;
                end
            end
            HI: begin
                if (timeout_w) begin
                    state_d = ERR;
                end else if (mem_ready) begin
                    state_d = half_q ? DONE : LO;
                end
            end
            LO: begin
                if (timeout_w) begin
                    state_d = ERR;
                end else if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                state_d = IDLE;
                addr_d  = '0;
                data_d  = '0;
                half_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        mem_valid_d = (state_d == HI) || (state_d == LO);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == HI) begin
            mem_addr_d  = addr_d;
            mem_wdata_d = half_d ? data_d[BEAT_W-1:0] : data_d[WORD_W-1:BEAT_W];
        end else if (state_d == LO) begin
            mem_addr_d  = addr_d + ADDR_W'(HALF_OFFSET);
            mem_wdata_d = data_d[BEAT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            half_q      <= 1'b0;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            half_q      <= half_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_word_store_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_word_store_serializer : scoreboard bench for the serializer     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_word_store_serializer;

    localparam int MAXW   = 6;
    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int M_WORD = 0;
    localparam int M_MIS  = 1;
    localparam int M_TMO  = 2;
    localparam int M_HALF = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [15:0] data;
        int          cyc;
        bit          abandon;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_half = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_cfg = 0;
    int   stall_cnt = 0;

    word_store_serializer #(
        .ADDR_W   (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
`ifdef HALF_STORE_EN
        .req_half  (req_half),
`endif
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic [31:0] a, input logic [15:0] d,
                                input int c, input bit ab);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c; e.abandon = ab;
        return e;
    endfunction

    // Memory responder followed by the scoreboard monitor, all on the falling edge.
    always @(negedge clk) begin
        if (mem_valid) begin
            if (stall_cnt < stall_cfg) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            mem_ready = 1'b0;
            stall_cnt = 0;
        end

        if (mem_valid) begin
            if (sb.size() == 0 || sb[0].kind != K_BEAT) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got addr %0h data %0h at cycle %0d", mem_addr, mem_wdata, cyc);
            end else begin
                chk("beat", {mem_addr, mem_wdata}, {sb[0].addr, sb[0].data});
                if (mem_ready) void'(sb.pop_front());
            end
        end
        if (err) begin
            while (sb.size() > 0 && sb[0].kind == K_BEAT && sb[0].abandon) void'(sb.pop_front());
            if (sb.size() == 0 || sb[0].kind != K_ERR) begin
                checks++; errors++;
                $display("FAIL unexpected_err: got err at cycle %0d expected none", cyc);
            end else begin
                chk("err_cycle", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
        if (done) begin
            if (sb.size() == 0 || sb[0].kind != K_DONE) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                chk("done_cycle", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    end

    // Accept happens on the posedge after the drive; its cycle index is cyc+1.
    task automatic store(input int mode, input logic [31:0] a, input logic [31:0] d, input bit half,
                         input int waits, input logic [31:0] a2, input logic [15:0] e_hi,
                         input logic [15:0] e_lo);
        int acc;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        stall_cfg = waits;
        req_valid = 1'b1; req_addr = a; req_data = d; req_half = half;
        acc = cyc + 1;
        case (mode)
            M_WORD: begin
                sb.push_back(mk(K_BEAT, a, e_hi, 0, 1'b0));
                sb.push_back(mk(K_BEAT, a2, e_lo, 0, 1'b0));
                sb.push_back(mk(K_DONE, '0, '0, acc + 2 + 2 * waits, 1'b0));
            end
            M_MIS: sb.push_back(mk(K_ERR, '0, '0, acc, 1'b0));
            M_TMO: begin
                sb.push_back(mk(K_BEAT, a, e_hi, 0, 1'b1));
                sb.push_back(mk(K_ERR, '0, '0, acc + MAXW, 1'b0));
            end
            default: begin
                sb.push_back(mk(K_BEAT, a, e_lo, 0, 1'b0));
                sb.push_back(mk(K_DONE, '0, '0, acc + 1 + waits, 1'b0));
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_half = 1'b0;
        chk("req_ready_busy", 64'({req_ready, busy}), 64'b01);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", 64'({req_ready, mem_valid, busy, done, err}), 64'b10000);
        chk("reset_bus", {mem_addr, 16'h0, mem_wdata}, 64'h0);

        store(M_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0, 32'h0000_0102, 16'hDEAD, 16'hBEEF);
        drain();
        store(M_WORD, 32'h0000_2000, 32'h0123_4567, 1'b0, 5, 32'h0000_2002, 16'h0123, 16'h4567);
        drain();

        store(M_MIS, 32'h0000_0101, 32'h1111_2222, 1'b0, 0, 32'h0, 16'h0, 16'h0);
        chk("mis_req_ready_err", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("mis_req_ready_back", 64'({req_ready, busy}), 64'b10);
        drain();
        store(M_MIS, 32'h0000_0102, 32'h3333_4444, 1'b0, 0, 32'h0, 16'h0, 16'h0);
        drain();

        store(M_TMO, 32'h0000_0400, 32'h5555_AAAA, 1'b0, 1000, 32'h0, 16'h5555, 16'h0);
        drain();

        // Reset asserted mid-LO: outputs must clear without waiting for a clock edge.
        store(M_WORD, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 5, 32'h0000_0302, 16'hCAFE, 16'hF00D);
        repeat (7) @(negedge clk);
        chk("lo_in_flight", {mem_addr, 16'h0, mem_wdata}, {32'h0000_0302, 16'h0, 16'hF00D});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'({req_ready, mem_valid, busy, done, err}), 64'b10000);
        chk("async_rst_bus", {mem_addr, 16'h0, mem_wdata}, 64'h0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;

        store(M_WORD, 32'hFFFF_FFF8, 32'h8001_7FFE, 1'b0, 0, 32'hFFFF_FFFA, 16'h8001, 16'h7FFE);
        drain();

`ifdef HALF_STORE_EN
        store(M_HALF, 32'h0000_0202, 32'h1234_ABCD, 1'b1, 0, 32'h0, 16'h0, 16'hABCD);
        drain();
        store(M_HALF, 32'h0000_0202, 32'h1234_ABCD, 1'b1, 2, 32'h0, 16'h0, 16'hABCD);
        drain();
        store(M_MIS, 32'h0000_0203, 32'h1234_ABCD, 1'b1, 0, 32'h0, 16'h0, 16'h0);
        drain();
        store(M_MIS, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 0, 32'h0, 16'h0, 16'h0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
